// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
//   Shared definitions for the AK-16 pipeline sequencing controller.
//   - state_e        : HALT drain FSM states (RUN / DRAIN / HALTED).
//   - *_DEFAULT      : default parameter values used by the controller.
//   - drain_cnt_width: width needed to count 0 .. DRAIN_CYCLES-1.
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int REG_AW_DEFAULT       = 4;
  localparam int DRAIN_CYCLES_DEFAULT = 4;
  localparam int CNT_W_DEFAULT        = 16;

  // A single-cycle drain still needs one bit of counter.
  function automatic int drain_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk  in  1  clock, posedge
//     rst  in  1  asynchronous active-high reset, clears the count
//     inc  in  1  count one event this cycle
//     q    out W  current count
// -----------------------------------------------------------------------------
module sat_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central sequencing controller for the AK-16 6-stage pipeline
//   (IF -> ID -> EX1 -> EX2 -> MEM -> WB).
//   - Load-use hazard detection against loads in EX1 and EX2 (ALU results are
//     forwarded, only load data arrives late, at the end of MEM).
//   - Stall / bubble generation and branch flush (flush wins over stall).
//   - HALT drain FSM: RUN -> DRAIN -> HALTED, with a sticky halted flag.
//   - Saturating performance counters for stall cycles and flush events.
//
//   Ports:
//     clk, rst                     clock (posedge), async active-high reset
//     id_rs1/id_rs2, id_use_rs*    ID source registers and their use flags
//     id_is_halt                   ID instruction is HALT
//     ex1_rd/ex1_is_load           EX1 destination and load flag
//     ex2_rd/ex2_is_load           EX2 destination and load flag
//     ex2_br_taken                 branch/jump resolved taken in EX2
//     fetch_en                     PC may advance / IF may fetch
//     stall_signal                 hold PC and IF/ID
//     id_bubble                    inject NOP into ID/EX1
//     flush_signal                 clear IF/ID, ID/EX1, EX1/EX2
//     halted                       sticky, HALT has retired
//     perf_stall / perf_flush      saturating stall-cycle / flush-event counts
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEFAULT,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_halt,
  input  logic [REG_AW-1:0] ex1_rd,
  input  logic              ex1_is_load,
  input  logic [REG_AW-1:0] ex2_rd,
  input  logic              ex2_is_load,
  input  logic              ex2_br_taken,
  output logic              fetch_en,
  output logic              stall_signal,
  output logic              id_bubble,
  output logic              flush_signal,
  output logic              halted,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_flush
);

  localparam int              DCW        = drain_cnt_width(DRAIN_CYCLES);
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_e         state_q;
  state_e         state_d;
  logic [DCW-1:0] drain_cnt_q;
  logic [DCW-1:0] drain_cnt_d;
  logic           halted_q;
  logic           halted_d;

  logic           hz1;
  logic           hz2;
  logic           stall_w;
  logic           flush_w;

  // A load in flight blocks a dependant in ID. R0 is hardwired zero, so a
  // "load to R0" never produces data anyone waits for.
  function automatic logic load_hit(
    input logic              is_load,
    input logic [REG_AW-1:0] rd,
    input logic              use1,
    input logic [REG_AW-1:0] rs1,
    input logic              use2,
    input logic [REG_AW-1:0] rs2
  );
    return is_load && (rd != '0) &&
           ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

  assign hz1 = load_hit(ex1_is_load, ex1_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
  assign hz2 = load_hit(ex2_is_load, ex2_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

  // Combinational control. While reset is held the pipeline is told to run
  // freely, whatever the stage inputs say. A flush squashes the dependant in
  // ID anyway, so it overrides the stall and keeps fetch on for the redirect.
  always_comb begin
    flush_w = 1'b0;
    stall_w = 1'b0;
    if (!rst) begin
      flush_w = ex2_br_taken && (state_q != ST_HALTED);
      stall_w = (hz1 || hz2) && !flush_w && (state_q == ST_RUN);
    end
  end

  assign flush_signal = flush_w;
  assign stall_signal = stall_w;
  assign id_bubble    = stall_w || flush_w || (!rst && (state_q != ST_RUN));
  assign fetch_en     = rst || ((state_q == ST_RUN) && !stall_w);
  assign halted       = halted_q;

  // HALT drain sequencing. drain_cnt tracks how far the HALT has travelled
  // past ID; only while it sits in EX1 (count 0) can an older branch in EX2
  // still squash it.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    unique case (state_q)
      ST_RUN: begin
        if (id_is_halt && !stall_w && !flush_w) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DCW'(1);
        if (ex2_br_taken && (drain_cnt_q == '0)) begin
          state_d     = ST_RUN;
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  // Stall/flush can only be active in RUN/DRAIN, so the counters implicitly
  // freeze once HALTED.
  sat_counter #(.W(CNT_W)) u_perf_stall (
    .clk (clk),
    .rst (rst),
    .inc (stall_w),
    .q   (perf_stall)
  );

  sat_counter #(.W(CNT_W)) u_perf_flush (
    .clk (clk),
    .rst (rst),
    .inc (flush_w),
    .q   (perf_flush)
  );

  // Once the HALT is past EX1, fetch is off and nothing younger than the
  // HALT can be a taken branch in EX2.
  a_no_late_branch_in_drain : assert property (
    @(posedge clk) disable iff (rst)
      !(ex2_br_taken && (state_q == ST_DRAIN) && (drain_cnt_q != '0))
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 4;
  localparam int CMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  id_rs1 = '0, id_rs2 = '0, ex1_rd = '0, ex2_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, id_is_halt = 0;
  logic        ex1_is_load = 0, ex2_is_load = 0, ex2_br_taken = 0;
  logic        fetch_en, stall_signal, id_bubble, flush_signal, halted;
  logic [15:0] perf_stall, perf_flush;

  pipeline_hazard_ctrl #(.REG_AW(4), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_halt(id_is_halt),
    .ex1_rd(ex1_rd), .ex1_is_load(ex1_is_load),
    .ex2_rd(ex2_rd), .ex2_is_load(ex2_is_load), .ex2_br_taken(ex2_br_taken),
    .fetch_en(fetch_en), .stall_signal(stall_signal), .id_bubble(id_bubble),
    .flush_signal(flush_signal), .halted(halted),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model: what the pipeline "is doing" in plain terms.
  bit m_running, m_draining, m_halted;
  int m_halt_age;        // edges the HALT has spent past ID
  int m_stalls, m_flushes;
  bit e_fetch, e_stall, e_bub, e_flush;
  logic [4:0] exp_o;

  function automatic bit waits_on(input bit ld, input logic [3:0] rd);
    if (!ld || rd == 0) return 0;
    return (id_use_rs1 && id_rs1 == rd) || (id_use_rs2 && id_rs2 == rd);
  endfunction

  function automatic void model_reset();
    m_running = 1; m_draining = 0; m_halted = 0; m_halt_age = 0;
    m_stalls = 0; m_flushes = 0;
  endfunction

  function automatic void predict();
    bit hz;
    hz = waits_on(ex1_is_load, ex1_rd) || waits_on(ex2_is_load, ex2_rd);
    if (rst) begin
      e_flush = 0; e_stall = 0; e_bub = 0; e_fetch = 1;
    end else begin
      e_flush = ex2_br_taken && !m_halted;
      e_stall = hz && !e_flush && m_running;
      e_bub   = e_stall || e_flush || !m_running;
      e_fetch = m_running && !e_stall;
    end
    exp_o = {e_fetch, e_stall, e_bub, e_flush, m_halted};
  endfunction

  function automatic void model_edge();
    predict();
    if (e_stall && m_stalls < CMAX) m_stalls++;
    if (e_flush && m_flushes < CMAX) m_flushes++;
    if (m_running) begin
      if (id_is_halt && !e_stall && !e_flush) begin
        m_running = 0; m_draining = 1; m_halt_age = 0;
      end
    end else if (m_draining) begin
      if (ex2_br_taken && m_halt_age == 0) begin
        m_draining = 0; m_running = 1;
      end else if (m_halt_age == DRAIN - 1) begin
        m_draining = 0; m_halted = 1;
      end else begin
        m_halt_age++;
      end
    end
  endfunction

  function automatic logic [4:0] obs();
    return {fetch_en, stall_signal, id_bubble, flush_signal, halted};
  endfunction

  task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input bit u1, input bit u2,
                       input bit hlt, input logic [3:0] r1, input bit l1,
                       input logic [3:0] r2, input bit l2, input bit br);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; id_is_halt = hlt;
    ex1_rd = r1; ex1_is_load = l1; ex2_rd = r2; ex2_is_load = l2; ex2_br_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; returns positioned at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    // Hazard and branch present while reset is held: outputs must stay benign.
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 1);
    #1 predict();
    nvec++;
    if (obs() !== 5'b10000) begin
      nmis++; $display("FAIL reset_outs got %b want %b", obs(), 5'b10000);
    end
    nvec++;
    if (perf_stall !== 16'd0 || perf_flush !== 16'd0) begin
      nmis++; $display("FAIL reset_cnt got %h/%h want 0/0", perf_stall, perf_flush);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // LW R1 ; ADD R2,R1,R3 : load walks EX1 -> EX2 -> MEM while ADD waits in ID.
  task automatic test_load_use_ex1();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1, 3, 1, 1, 0, 1, 1, 0, 0, 0);
        1: drive(1, 3, 1, 1, 0, 0, 0, 1, 1, 0);
        default: drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
      endcase
      #1 predict();
      nvec++;
      if (obs() !== exp_o) begin
        nmis++; $display("FAIL load_ex1[%0d] got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
    nvec++;
    if (perf_stall !== 16'd2) begin
      nmis++; $display("FAIL load_ex1_perf got %0d want 2", perf_stall);
    end
  endtask

  // LW R1 ; NOP ; ADD R2,R1,R1 -> one stall. Then load to R0 vs source R0.
  task automatic test_load_use_ex2_r0();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
        1: drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 1, 1, 0, 0, 1, 0, 1, 0);
      endcase
      #1 predict();
      nvec++;
      if (obs() !== exp_o) begin
        nmis++; $display("FAIL load_ex2[%0d] got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
    nvec++;
    if (perf_stall !== 16'd1) begin
      nmis++; $display("FAIL load_ex2_perf got %0d want 1", perf_stall);
    end
  endtask

  task automatic test_flush_beats_stall();
    do_reset();
    drive(5, 0, 1, 0, 0, 5, 1, 0, 0, 1);
    #1 predict();
    nvec++;
    if (obs() !== 5'b10110) begin
      nmis++; $display("FAIL flush_over_stall got %b want %b", obs(), 5'b10110);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (perf_flush !== 16'd1 || perf_stall !== 16'd0) begin
      nmis++; $display("FAIL flush_perf got %0d/%0d want 1/0", perf_flush, perf_stall);
    end
  endtask

  task automatic test_halt_drain();
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #1 predict();
    nvec++;
    if (obs() !== exp_o) begin
      nmis++; $display("FAIL halt_issue got %b want %b", obs(), exp_o);
    end
    tick();
    idle();
    for (int e = 1; e <= 4; e++) begin
      #1 predict();
      nvec++;
      if (obs() !== exp_o || fetch_en !== 1'b0 || halted !== 1'b0) begin
        nmis++; $display("FAIL halt_drain[%0d] got %b want %b", e, obs(), exp_o);
      end
      tick();
    end
    #1;
    nvec++;
    if (halted !== 1'b1 || fetch_en !== 1'b0) begin
      nmis++; $display("FAIL halt_done got halted=%b fetch=%b want 1/0", halted, fetch_en);
    end
    // HALTED ignores everything until reset.
    for (int i = 0; i < 8; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1, 1, $urandom_range(0, 1),
            $urandom_range(0, 3), 1, $urandom_range(0, 3), 1, $urandom_range(0, 1));
      #1 predict();
      nvec++;
      if (obs() !== 5'b00101 || perf_flush !== 16'd0) begin
        nmis++; $display("FAIL halted_absorb[%0d] got %b want %b", i, obs(), 5'b00101);
      end
      tick();
    end
  endtask

  task automatic test_halt_squash();
    do_reset();
    // Same-cycle flush squashes the HALT in ID.
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tick();
    idle();
    #1;
    nvec++;
    if (fetch_en !== 1'b1 || id_bubble !== 1'b0) begin
      nmis++; $display("FAIL halt_flushed got fetch=%b bub=%b want 1/0", fetch_en, id_bubble);
    end
    // HALT enters DRAIN, then an older branch resolves taken.
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 predict();
    nvec++;
    if (obs() !== exp_o) begin
      nmis++; $display("FAIL squash_br got %b want %b", obs(), exp_o);
    end
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++;
      if (fetch_en !== 1'b1 || halted !== 1'b0) begin
        nmis++; $display("FAIL squash_run[%0d] got fetch=%b halted=%b want 1/0", i, fetch_en, halted);
      end
      tick();
    end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    drive(7, 0, 1, 0, 0, 7, 1, 0, 0, 0);
    for (int i = 0; i < CMAX + 6; i++) tick();
    #1;
    nvec++;
    if (perf_stall !== 16'hFFFF || stall_signal !== 1'b1) begin
      nmis++; $display("FAIL sat_stall got %h want ffff", perf_stall);
    end
    tick();
    #1;
    nvec++;
    if (perf_stall !== 16'hFFFF) begin
      nmis++; $display("FAIL sat_hold got %h want ffff", perf_stall);
    end
    // Enter DRAIN, then async reset part way through.
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    nvec++;
    if (perf_stall !== 16'd0 || perf_flush !== 16'd0 || halted !== 1'b0 || fetch_en !== 1'b1) begin
      nmis++; $display("FAIL rst_mid_drain got cnt=%h/%h halted=%b fetch=%b want 0/0/0/1",
                       perf_stall, perf_flush, halted, fetch_en);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(2, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    #1 predict();
    nvec++;
    if (obs() !== exp_o || stall_signal !== 1'b1) begin
      nmis++; $display("FAIL run_after_rst got %b want %b", obs(), exp_o);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit br;
      br = ($urandom_range(0, 7) == 0);
      if (m_draining && m_halt_age != 0) br = 0;
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), br);
      #1 predict();
      nvec++;
      if (obs() !== exp_o) begin
        nmis++; $display("FAIL rand[%0d] outs got %b want %b", i, obs(), exp_o);
      end
      nvec++;
      if (perf_stall !== 16'(m_stalls) || perf_flush !== 16'(m_flushes)) begin
        nmis++; $display("FAIL rand[%0d] cnt got %0d/%0d want %0d/%0d",
                         i, perf_stall, perf_flush, m_stalls, m_flushes);
      end
      tick();
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_load_use_ex1();
    test_load_use_ex2_r0();
    test_flush_beats_stall();
    test_halt_drain();
    test_halt_squash();
    test_saturate_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
